// File: rtl/sobel_edge_if.sv
// Grayscale pixel stream in and Sobel edge stream out, grouped for sobel_edge.
// master drives pixels and watches edges; slave is the sobel_edge side.
interface sobel_edge_if;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] gray_in;
    logic       edge_valid;
    logic       edge_sof;
    logic       edge_eof;
    logic [7:0] edge_out;

    modport master (
        output pix_valid, pix_sof, gray_in,
        input  edge_valid, edge_sof, edge_eof, edge_out
    );

    modport slave (
        input  pix_valid, pix_sof, gray_in,
        output edge_valid, edge_sof, edge_eof, edge_out
    );
endinterface

// File: rtl/sobel_edge.sv
// 3x3 Sobel |Gx|+|Gy| on a raster grayscale stream; interior pixels only; SOBEL_THRESH_EN selects 0/255 output.
// Latency: pixel completing a window in cycle N -> edge_valid in cycle N+2, independent of input gaps.
// Backpressure: none; input accepted whenever pix_valid, pipeline advances every cycle.
module sobel_edge #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int THRESH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    sobel_edge_if.slave px
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    generate
        if (IMG_W < 3 || IMG_H < 3 || THRESH < 0 || THRESH > 2047) begin : g_bad_cfg
            $error("sobel_edge: IMG_W/IMG_H must be >= 3 and THRESH within 0..2047");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          sof_hit;

    // A pix_sof pixel is (0,0) no matter where the counters were.
    always_comb begin
        sof_hit = px.pix_valid & px.pix_sof;
        cur_col = sof_hit ? '0 : col;
        cur_row = sof_hit ? '0 : row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (px.pix_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds the previous line, lb1 the one before it
    // ------------------------------------------------------------------
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];
    logic [7:0] top_px;
    logic [7:0] mid_px;

    always_comb begin
        top_px = lb1[cur_col];
        mid_px = lb0[cur_col];
    end

    always_ff @(posedge clk) begin
        if (px.pix_valid) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= px.gray_in;
        end
    end

    // ------------------------------------------------------------------
    // Window: two stored columns (left, middle); the incoming column is
    // the right column, so the kernel sees the full 3x3 in the accept cycle.
    // ------------------------------------------------------------------
    logic [7:0] t_l, t_m, m_l, m_m, b_l, b_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_l <= '0;
            t_m <= '0;
            m_l <= '0;
            m_m <= '0;
            b_l <= '0;
            b_m <= '0;
        end else if (px.pix_valid) begin
            t_l <= t_m;
            t_m <= top_px;
            m_l <= m_m;
            m_m <= mid_px;
            b_l <= b_m;
            b_m <= px.gray_in;
        end
    end

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    logic signed [10:0] gx_c, gy_c;
    logic               win_vld, win_sof, win_eof;

    always_comb begin
        gx_c = ext(top_px) + (ext(mid_px) <<< 1) + ext(px.gray_in)
             - ext(t_l)    - (ext(m_l)    <<< 1) - ext(b_l);
        gy_c = ext(b_l)    + (ext(b_m)    <<< 1) + ext(px.gray_in)
             - ext(t_l)    - (ext(t_m)    <<< 1) - ext(top_px);
        win_vld = px.pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        win_sof = (cur_row == RW'(2)) && (cur_col == CW'(2));
        win_eof = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end

    // ------------------------------------------------------------------
    // Stage 1: signed gradients
    // ------------------------------------------------------------------
    logic               s1_vld, s1_sof, s1_eof;
    logic signed [10:0] s1_gx, s1_gy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_sof <= 1'b0;
            s1_eof <= 1'b0;
            s1_gx  <= '0;
            s1_gy  <= '0;
        end else begin
            s1_vld <= win_vld;
            s1_sof <= win_vld & win_sof;
            s1_eof <= win_vld & win_eof;
            if (win_vld) begin
                s1_gx <= gx_c;
                s1_gy <= gy_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude, saturation or threshold
    // ------------------------------------------------------------------
    logic [10:0] abs_gx, abs_gy, mag;
    logic [7:0]  pix_res;

    always_comb begin
        abs_gx = s1_gx[10] ? -s1_gx : s1_gx;
        abs_gy = s1_gy[10] ? -s1_gy : s1_gy;
        mag    = abs_gx + abs_gy;
`ifdef SOBEL_THRESH_EN
        pix_res = (mag >= 11'(THRESH)) ? 8'd255 : 8'd0;
`else
        pix_res = (mag > 11'd255) ? 8'd255 : mag[7:0];
`endif
    end

    logic       edge_vld_q, edge_sof_q, edge_eof_q;
    logic [7:0] edge_dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_vld_q <= 1'b0;
            edge_sof_q <= 1'b0;
            edge_eof_q <= 1'b0;
            edge_dat_q <= '0;
        end else begin
            edge_vld_q <= s1_vld;
            edge_sof_q <= s1_sof;
            edge_eof_q <= s1_eof;
            edge_dat_q <= s1_vld ? pix_res : 8'd0;
        end
    end

    assign px.edge_valid = edge_vld_q;
    assign px.edge_sof   = edge_sof_q;
    assign px.edge_eof   = edge_eof_q;
    assign px.edge_out   = edge_dat_q;
endmodule

// File: tb/tb_sobel_edge.sv
// Randomised bench for sobel_edge on an 8x8 frame against a frame-array Sobel model.
// Build with or without SOBEL_THRESH_EN; the model follows the same switch.
module tb_sobel_edge;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TH = 128;
`ifdef SOBEL_THRESH_EN
    localparam int RAMP_V = 0;
`else
    localparam int RAMP_V = 80;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_edge_if bus();

    sobel_edge #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .px    (bus)
    );

    typedef struct {
        int val;
        bit sof;
        bit eof;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   img [H][W];
    int   m_row, m_col;
    int   n_checks, n_errors;
    int   cyc;
    int   n_out, n_eof, n_255, n_ramp, n_zero;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_mag(input int r, input int c);
        int p [3][3];
        int gx, gy, mag;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r - 2 + i][c - 2 + j];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= TH) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    function automatic int pix_val(input int kind, input int r, input int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : 200;
            2:       return 10 * c;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.pix_valid = 1'b0;
            bus.pix_sof   = 1'b0;
        end
    endtask

    // Present one pixel (after optional random gaps) and update the model.
    task automatic drive_px(input int v, input bit sof, input int gap_pct);
        int gaps = 0;
        while (gaps < 4 && int'($urandom_range(99)) < gap_pct) gaps++;
        repeat (gaps) begin
            @(posedge clk);
            #1;
            bus.pix_valid = 1'b0;
            bus.pix_sof   = 1'b0;
            bus.gray_in   = 8'($urandom_range(255));
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.gray_in   = 8'(v);
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = v;
        if (m_row >= 2 && m_col >= 2)
            expq.push_back('{ref_mag(m_row, m_col), (m_row == 2 && m_col == 2),
                             (m_row == H - 1 && m_col == W - 1), cyc + 2});
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic run_frame(input int kind, input int gap_pct, input bit use_sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive_px(pix_val(kind, r, c), use_sof && r == 0 && c == 0, gap_pct);
    endtask

    task automatic clr_counts();
        n_out  = 0;
        n_eof  = 0;
        n_255  = 0;
        n_ramp = 0;
        n_zero = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                chk("missing_out_cycle", cyc, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (bus.edge_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("edge_out", int'(bus.edge_out), e.val);
                    chk("edge_sof", int'(bus.edge_sof), int'(e.sof));
                    chk("edge_eof", int'(bus.edge_eof), int'(e.eof));
                    chk("latency_cycle", cyc, e.cyc);
                end
                n_out++;
                if (bus.edge_eof) n_eof++;
                if (bus.edge_out == 8'd255) n_255++;
                if (int'(bus.edge_out) == RAMP_V) n_ramp++;
                if (bus.edge_out == 8'd0) n_zero++;
            end
        end
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.gray_in   = 8'd0;
        m_row = 0;
        m_col = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_edge_valid", int'(bus.edge_valid), 0);
        chk("rst_edge_sof",   int'(bus.edge_sof), 0);
        chk("rst_edge_eof",   int'(bus.edge_eof), 0);
        chk("rst_edge_out",   int'(bus.edge_out), 0);
        rst_n = 1'b1;
        idle(2);

        clr_counts();
        run_frame(0, 0, 1'b1);
        idle(5);
        chk("flat_count", n_out, 36);
        chk("flat_zero",  n_zero, 36);
        chk("flat_eof",   n_eof, 1);

        clr_counts();
        run_frame(1, 0, 1'b1);
        idle(5);
        chk("step_count", n_out, 36);
        chk("step_255",   n_255, 12);

        clr_counts();
        run_frame(2, 0, 1'b1);
        idle(5);
        chk("ramp_count", n_out, 36);
        chk("ramp_value", n_ramp, 36);

        clr_counts();
        run_frame(1, 50, 1'b1);
        idle(5);
        chk("gap_step_count", n_out, 36);
        chk("gap_step_255",   n_255, 12);

        // Second random frame relies on the counter wrap, no pix_sof.
        clr_counts();
        run_frame(3, 30, 1'b1);
        run_frame(3, 30, 1'b0);
        idle(5);
        chk("rand_count", n_out, 72);
        chk("rand_eof",   n_eof, 2);

        // Abort a frame at row 3 col 5 with a fresh pix_sof.
        clr_counts();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || (r == 3 && c < 5))
                    drive_px(pix_val(3, r, c), r == 0 && c == 0, 20);
        run_frame(1, 0, 1'b1);
        idle(5);
        chk("abort_count", n_out, 9 + 36);
        chk("abort_eof",   n_eof, 1);

        // Reset in row 4 while outputs are in flight.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 4 || (r == 4 && c <= 3))
                    drive_px(pix_val(3, r, c), r == 0 && c == 0, 0);
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_edge_valid", int'(bus.edge_valid), 0);
        chk("midrst_edge_out",   int'(bus.edge_out), 0);
        expq.delete();
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_counts();
        run_frame(0, 0, 1'b0);
        idle(5);
        chk("post_rst_count", n_out, 36);
        chk("post_rst_zero",  n_zero, 36);
        chk("post_rst_eof",   n_eof, 1);

        chk("drain_queue", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sobel_edge.md
# sobel_edge

Downstream consumer of the colour/grayscale conversion stage: takes the 8-bit grayscale pixel stream (raster order) and produces a 3x3 Sobel gradient-magnitude stream for the edge-display/overlay path. Two internal line buffers build the 3x3 window on the fly. A two-stage pipeline computes |Gx|+|Gy| with saturation to 8 bits. Only interior pixels (those with a full 3x3 neighbourhood) are emitted; there is no backpressure.

## Interface
- IMG_W, 64: pixels per line (>= 3).
- IMG_H, 64: lines per frame (>= 3).
- THRESH, 128: binarisation threshold; used only when SOBEL_THRESH_EN is defined.
- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- pix_valid  in  1  gray_in/pix_sof are valid this cycle; gaps allowed.
- pix_sof  in  1  qualifies the first pixel of a frame (row 0, col 0).
- gray_in  in  8  grayscale pixel, unsigned.
- edge_valid  out  1  edge_out valid this cycle (single-cycle per output pixel).
- edge_sof  out  1  with edge_valid on the first output of a frame (centre row 1, col 1).
- edge_eof  out  1  with edge_valid on the last output of a frame (centre IMG_H-2, IMG_W-2).
- edge_out  out  8  gradient magnitude (or 0/255 when thresholded).

## Operation
- Counters:
  - col counts 0..IMG_W-1.
  - row counts 0..IMG_H-1.
  - Both advance only on pix_valid.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the last pixel of a frame, so the next pixel is treated as (0,0) even without pix_sof.
- pix_sof with pix_valid forces that pixel to (0,0), including mid-frame. Line-buffer contents are not cleared. In-flight pipeline outputs still complete.
- Line buffers: two IMG_W x 8 memories addressed by col.
  - On each valid pixel, lb1[col] is read (row-2 value) and lb0[col] is read (row-1 value).
  - Then lb1[col] <= lb0[col] and lb0[col] <= gray_in.
  - A 3-column shift register of {row-2, row-1, row} forms the window.
- Window valid when the accepted pixel has row >= 2 and col >= 2. The centre is (row-1, col-1).
- Kernels: Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Stage 1 registers Gx, Gy as 11-bit signed.
- Stage 2:
  - mag = |Gx| + |Gy|, 11-bit unsigned, max 2040.
  - edge_out = (mag > 255) ? 255 : mag[7:0].
- edge_sof is set for centre (1,1); edge_eof for centre (IMG_H-2, IMG_W-2). The flags are carried through the pipeline alongside valid.
- Output count per complete frame: (IMG_W-2)*(IMG_H-2).

## Timing
- Reset values: edge_valid=0, edge_sof=0, edge_eof=0, edge_out=0.
- Reset also sets col=0, row=0, pipeline valids=0 and window registers=0. Line-buffer contents are don't-care.
- Latency: the pixel completing a window is accepted in cycle N; edge_valid is asserted in cycle N+2. Latency is fixed regardless of input gaps.
- Pipeline stages advance every cycle and are tagged with a valid bit. Idle input produces edge_valid=0 two cycles later.
- Back-to-back valid pixels give back-to-back outputs within a row. No outputs are produced for col 0..1 or row 0..1 inputs.
- Reset asserted mid-frame clears all outputs immediately (asynchronously). After release, the first pixel is (0,0).

## Configuration
- SOBEL_THRESH_EN:
  - Defined: edge_out = (mag >= THRESH) ? 8'd255 : 8'd0. Latency is unchanged.
  - Undefined: edge_out is the saturated magnitude; THRESH is unused.

## Test plan
- Flat frame, all pixels 100, IMG_W=IMG_H=8 -> 36 outputs, all 0; edge_sof on the 1st output, edge_eof on the 36th.
- Vertical step, 8x8 frame, col<4 = 0, col>=4 = 200 -> centres col 3 and 4 give Gx=800 -> edge_out=255; all other centres give 0.
- Horizontal ramp, gray = 10*col -> every output is 80.
  - With SOBEL_THRESH_EN and THRESH=128 -> every output is 0.
  - With THRESH=64 -> every output is 255.
- Random pix_valid gaps (~50% duty) on the step frame -> identical output values and sequence.
  - Each edge_valid occurs exactly 2 cycles after its completing input.
- pix_sof reasserted at row 3, col 5 of frame 1 -> counters restart; the next output is the new frame's centre (1,1) with edge_sof=1.
  - No output carries edge_eof for the aborted frame.
- rst_n pulled low during row 4 -> edge_valid=0 and edge_out=0 immediately.
  - A following full flat frame yields exactly 36 zero outputs.
